char_buf_udp_reporter: RTL

// - Transmit-side counterpart of the UDP->char-RAM writer: reads the OSD character buffer back and

---
 rtl/char_buf_udp_reporter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/char_buf_udp_reporter.sv
// ---------------------------------------------------------------------------
// char_buf_udp_reporter
//
// Reads the OSD character buffer back out of the char RAM and sends it as a
// single UDP payload through the eth_udp TX stream when asked to.
//
// Packet payload: HDR_MAGIC, len, char[0] .. char[len-1] [, checksum]
//   len = min(RAM[STRLENDATA_SAVED_ADDR], MAX_CHARS), captured once per packet.
//
// Optional feature macro: CHAR_BUF_REPORT_CRC_EN
//   defined     -> one trailing byte = XOR of magic, len and all chars,
//                  tsize = len + 3, the checksum byte carries last.
//   not defined -> no checksum byte, tsize = len + 2.
//
// Ports
//   clk             in   system clock (char RAM and eth_udp user side)
//   rst             in   synchronous reset, active-high
//   report_req      in   one-cycle request for a report packet
//   ram_rd_addr     out  char RAM read address (registered)
//   ram_dout        in   char RAM read data, valid one clock after the address
//   udp_tx_m_start  out  packet-start strobe, tsize valid with it
//   udp_tx_m_tsize  out  payload byte count
//   udp_tx_m_data   out  payload byte
//   udp_tx_m_valid  out  payload byte valid
//   udp_tx_m_last   out  final payload byte marker
//   udp_tx_m_ready  in   sink ready; start/byte accepted when high
//   busy            out  high while a packet is in progress
//   pkt_cnt         out  count of completely sent packets (wraps)
// ---------------------------------------------------------------------------
module char_buf_udp_reporter #(
  parameter int         CHAR_BUFFER_ADDR_WIDTH = 11,
  parameter int         STRLENDATA_SAVED_ADDR  = 1023,
  parameter int         CHAR_BASE_ADDR         = 0,
  parameter int         MAX_CHARS              = 255,
  parameter logic [7:0] HDR_MAGIC              = 8'h5A
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              report_req,
  output logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [7:0]                        ram_dout,
  output logic                              udp_tx_m_start,
  output logic [15:0]                       udp_tx_m_tsize,
  output logic [7:0]                        udp_tx_m_data,
  output logic                              udp_tx_m_valid,
  output logic                              udp_tx_m_last,
  input  logic                              udp_tx_m_ready,
  output logic                              busy,
  output logic [15:0]                       pkt_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LEN,
    S_WAIT_LEN,
    S_START,
    S_HDR0,
    S_HDR1,
    S_FETCH,
    S_SEND,
`ifdef CHAR_BUF_REPORT_CRC_EN
    S_CRC,
`endif
    S_DONE
  } state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_CHARS);

  // State that follows the last character (or the header when len is 0).
`ifdef CHAR_BUF_REPORT_CRC_EN
  localparam state_t     TAIL_STATE = S_CRC;
  localparam logic [15:0] HDR_EXTRA = 16'd3;
`else
  localparam state_t     TAIL_STATE = S_DONE;
  localparam logic [15:0] HDR_EXTRA = 16'd2;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [7:0]  fetch_idx;
  logic [7:0]  char_hold;
  logic        send_first;
  logic        pending;
  logic        last_char;
  logic [7:0]  len_clamped;
`ifdef CHAR_BUF_REPORT_CRC_EN
  logic [7:0]  crc_q;
`endif

  assign busy        = (state != S_IDLE);
  assign last_char   = (idx_q == len_q - 8'd1);
  assign len_clamped = (ram_dout > MAX_LEN) ? MAX_LEN : ram_dout;

  // Next-state and stream outputs. Outputs depend only on state so that
  // ready never feeds back combinationally into data/valid/start.
  // In the first SEND cycle the RAM word is taken straight from ram_dout;
  // afterwards the captured copy is used so a stalled byte stays stable.
  always_comb begin
    state_nxt      = state;
    fetch_idx      = idx_q;
    udp_tx_m_start = 1'b0;
    udp_tx_m_tsize = 16'd0;
    udp_tx_m_data  = 8'd0;
    udp_tx_m_valid = 1'b0;
    udp_tx_m_last  = 1'b0;
    case (state)
      S_IDLE:     if (report_req) state_nxt = S_RD_LEN;
      S_RD_LEN:   state_nxt = S_WAIT_LEN;
      S_WAIT_LEN: state_nxt = S_START;
      S_START: begin
        udp_tx_m_start = 1'b1;
        udp_tx_m_tsize = 16'(len_q) + HDR_EXTRA;
        if (udp_tx_m_ready) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        udp_tx_m_data  = HDR_MAGIC;
        udp_tx_m_valid = 1'b1;
        if (udp_tx_m_ready) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        udp_tx_m_data  = len_q;
        udp_tx_m_valid = 1'b1;
`ifndef CHAR_BUF_REPORT_CRC_EN
        udp_tx_m_last  = (len_q == 8'd0);
`endif
        if (udp_tx_m_ready) state_nxt = (len_q == 8'd0) ? TAIL_STATE : S_FETCH;
      end
      S_FETCH:    state_nxt = S_SEND;
      S_SEND: begin
        udp_tx_m_data  = send_first ? ram_dout : char_hold;
        udp_tx_m_valid = 1'b1;
`ifndef CHAR_BUF_REPORT_CRC_EN
        udp_tx_m_last  = last_char;
`endif
        if (udp_tx_m_ready) begin
          fetch_idx = idx_q + 8'd1;
          state_nxt = last_char ? TAIL_STATE : S_FETCH;
        end
      end
`ifdef CHAR_BUF_REPORT_CRC_EN
      S_CRC: begin
        udp_tx_m_data  = crc_q;
        udp_tx_m_valid = 1'b1;
        udp_tx_m_last  = 1'b1;
        if (udp_tx_m_ready) state_nxt = S_DONE;
      end
`endif
      S_DONE:     state_nxt = (pending || report_req) ? S_RD_LEN : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register plus datapath. The RAM address is registered on entry to
  // RD_LEN/FETCH and otherwise held, so the RAM only ever sees addresses the
  // packet actually needs. A request arriving while busy (including in DONE)
  // is remembered once and consumed when DONE launches the next packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      char_hold   <= 8'd0;
      send_first  <= 1'b0;
      pending     <= 1'b0;
      ram_rd_addr <= '0;
      pkt_cnt     <= 16'd0;
`ifdef CHAR_BUF_REPORT_CRC_EN
      crc_q       <= 8'd0;
`endif
    end else begin
      state      <= state_nxt;
      send_first <= (state == S_FETCH);

      if (state_nxt == S_RD_LEN)
        ram_rd_addr <= CHAR_BUFFER_ADDR_WIDTH'(STRLENDATA_SAVED_ADDR);
      else if (state_nxt == S_FETCH)
        ram_rd_addr <= CHAR_BUFFER_ADDR_WIDTH'(CHAR_BASE_ADDR + int'(fetch_idx));

      if (state == S_WAIT_LEN) len_q <= len_clamped;

      if (state == S_START)
        idx_q <= 8'd0;
      else if (state == S_SEND && udp_tx_m_ready)
        idx_q <= idx_q + 8'd1;

      if (send_first) char_hold <= ram_dout;

`ifdef CHAR_BUF_REPORT_CRC_EN
      if (state == S_START)
        crc_q <= 8'd0;
      else if (udp_tx_m_valid && udp_tx_m_ready && state != S_CRC)
        crc_q <= crc_q ^ udp_tx_m_data;
`endif

      if (state == S_DONE) pkt_cnt <= pkt_cnt + 16'd1;

      if (state == S_DONE)
        pending <= 1'b0;
      else if (report_req && state != S_IDLE)
        pending <= 1'b1;
    end
  end

endmodule
